// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller for the 4-way set-associative cache: victim select, optional writeback, fill, install, replay.
// Define CACHE_WRITEBACK_EN to enable writeback of dirty victims; default build is write-through.
module cache_miss_ctrl (
   input  logic            clk,
   input  logic            rst,
   input  logic            miss_req,
   input  logic [31:0]     miss_addr,
   input  logic [3:0]      valid_vec,
   input  logic [3:0]      dirty_vec,
   input  logic [95:0]     tag_vec,
   input  logic [1023:0]   data_vec,
   input  logic [2:0]      lru_bits,
   output logic [31:0]     dfp_addr,
   output logic            dfp_read,
   output logic            dfp_write,
   output logic [255:0]    dfp_wdata,
   input  logic [255:0]    dfp_rdata,
   input  logic            dfp_resp,
   output logic            fill_we,
   output logic [1:0]      fill_way,
   output logic [3:0]      fill_set,
   output logic [23:0]     fill_tag,
   output logic [255:0]    fill_data,
   output logic            miss_done,
   output logic            busy
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WRITEBACK = 3'd1,
      S_FILL      = 3'd2,
      S_INSTALL   = 3'd3,
      S_REPLAY    = 3'd4
   } state_t;

   // Handshake: a DFP strobe stays high with stable address/data until dfp_resp is
   // sampled high at a rising edge; the strobe drops in the following cycle.
   state_t        state_q, state_d;
   logic [31:5]   line_addr_q;
   logic [1:0]    way_q;
   logic [1:0]    victim_way;

   logic [31:0]   dfp_addr_d;
   logic          dfp_read_d, dfp_write_d, fill_we_d, miss_done_d, busy_d;
   logic [255:0]  dfp_wdata_d, fill_data_d;
   logic [1:0]    fill_way_d;
   logic [3:0]    fill_set_d;
   logic [23:0]   fill_tag_d;

   // Free way first, otherwise tree-PLRU.
   always_comb begin
      victim_way = 2'd0;
      if (!valid_vec[0])      victim_way = 2'd0;
      else if (!valid_vec[1]) victim_way = 2'd1;
      else if (!valid_vec[2]) victim_way = 2'd2;
      else if (!valid_vec[3]) victim_way = 2'd3;
      else if (!lru_bits[2])  victim_way = lru_bits[1] ? 2'd1 : 2'd0;
      else                    victim_way = lru_bits[0] ? 2'd3 : 2'd2;
   end

`ifdef CACHE_WRITEBACK_EN
   logic [23:0]   vtag_q;
   logic [255:0]  vline_q;
   logic [23:0]   victim_tag;
   logic [255:0]  victim_line;
   logic          victim_dirty;

   assign victim_tag   = tag_vec[victim_way*24 +: 24];
   assign victim_line  = data_vec[victim_way*256 +: 256];
   assign victim_dirty = valid_vec[victim_way] & dirty_vec[victim_way];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vtag_q  <= '0;
         vline_q <= '0;
      end else if (state_q == S_IDLE && miss_req) begin
         vtag_q  <= victim_tag;
         vline_q <= victim_line;
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{dirty_vec, tag_vec, data_vec};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         line_addr_q <= '0;
         way_q       <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && miss_req) begin
            line_addr_q <= miss_addr[31:5];
            way_q       <= victim_way;
         end
      end
   end

   // Outputs are computed for the next state and registered alongside it.
   always_comb begin
      state_d     = state_q;
      dfp_addr_d  = '0;
      dfp_read_d  = 1'b0;
      dfp_write_d = 1'b0;
      dfp_wdata_d = '0;
      fill_we_d   = 1'b0;
      fill_way_d  = '0;
      fill_set_d  = '0;
      fill_tag_d  = '0;
      fill_data_d = '0;
      miss_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (miss_req) begin
`ifdef CACHE_WRITEBACK_EN
               if (victim_dirty) begin
                  // The 24-bit tag covers addr[31:8], so it overlaps set bit 8.
                  state_d     = S_WRITEBACK;
                  dfp_write_d = 1'b1;
                  dfp_addr_d  = {victim_tag, miss_addr[7:5], 5'b0};
                  dfp_wdata_d = victim_line;
               end else begin
                  state_d    = S_FILL;
                  dfp_read_d = 1'b1;
                  dfp_addr_d = {miss_addr[31:5], 5'b0};
               end
`else
               state_d    = S_FILL;
               dfp_read_d = 1'b1;
               dfp_addr_d = {miss_addr[31:5], 5'b0};
`endif
            end
         end
         S_WRITEBACK: begin
`ifdef CACHE_WRITEBACK_EN
            if (dfp_resp) begin
               state_d    = S_FILL;
               dfp_read_d = 1'b1;
               dfp_addr_d = {line_addr_q, 5'b0};
            end else begin
               dfp_write_d = 1'b1;
               dfp_addr_d  = {vtag_q, line_addr_q[7:5], 5'b0};
               dfp_wdata_d = vline_q;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_FILL: begin
            if (dfp_resp) begin
               state_d     = S_INSTALL;
               fill_we_d   = 1'b1;
               fill_way_d  = way_q;
               fill_set_d  = line_addr_q[8:5];
               fill_tag_d  = line_addr_q[31:8];
               fill_data_d = dfp_rdata;
            end else begin
               dfp_read_d = 1'b1;
               dfp_addr_d = {line_addr_q, 5'b0};
            end
         end
         S_INSTALL: begin
            state_d     = S_REPLAY;
            miss_done_d = 1'b1;
         end
         S_REPLAY: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dfp_addr  <= '0;
         dfp_read  <= 1'b0;
         dfp_write <= 1'b0;
         dfp_wdata <= '0;
         fill_we   <= 1'b0;
         fill_way  <= '0;
         fill_set  <= '0;
         fill_tag  <= '0;
         fill_data <= '0;
         miss_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         dfp_addr  <= dfp_addr_d;
         dfp_read  <= dfp_read_d;
         dfp_write <= dfp_write_d;
         dfp_wdata <= dfp_wdata_d;
         fill_we   <= fill_we_d;
         fill_way  <= fill_way_d;
         fill_set  <= fill_set_d;
         fill_tag  <= fill_tag_d;
         fill_data <= fill_data_d;
         miss_done <= miss_done_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed, table-driven bench for cache_miss_ctrl plus hand-written multi-cycle sequences.
module tb_cache_miss_ctrl;

   logic            clk = 1'b0;
   logic            rst;
   logic            miss_req;
   logic [31:0]     miss_addr;
   logic [3:0]      valid_vec, dirty_vec;
   logic [95:0]     tag_vec;
   logic [1023:0]   data_vec;
   logic [2:0]      lru_bits;
   logic [31:0]     dfp_addr;
   logic            dfp_read, dfp_write;
   logic [255:0]    dfp_wdata, dfp_rdata;
   logic            dfp_resp;
   logic            fill_we;
   logic [1:0]      fill_way;
   logic [3:0]      fill_set;
   logic [23:0]     fill_tag;
   logic [255:0]    fill_data;
   logic            miss_done, busy;

   int n_cmp = 0;
   int n_err = 0;
   int fill_cnt = 0;
   int exp_fills = 0;

   cache_miss_ctrl dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .valid_vec(valid_vec), .dirty_vec(dirty_vec), .tag_vec(tag_vec),
      .data_vec(data_vec), .lru_bits(lru_bits), .dfp_addr(dfp_addr),
      .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
      .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp), .fill_we(fill_we),
      .fill_way(fill_way), .fill_set(fill_set), .fill_tag(fill_tag),
      .fill_data(fill_data), .miss_done(miss_done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fill_we === 1'b1) fill_cnt++;
      if (dfp_read === 1'b1 && dfp_write === 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL strobe_overlap: dfp_read=1 dfp_write=1 required not both");
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  valid;
      logic [3:0]  dirty;
      logic [2:0]  lru;
      int          delay;
      logic [1:0]  exp_way;
      logic [31:0] exp_dfp;
      logic [3:0]  exp_set;
      logic [23:0] exp_tag;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one miss from IDLE; returns one cycle after miss_done with miss_req low.
   task automatic run_miss(input vec_t v, input logic [255:0] rdata);
      miss_req  = 1'b1;
      miss_addr = v.addr;
      valid_vec = v.valid;
      dirty_vec = v.dirty;
      lru_bits  = v.lru;
      step();
      check("read_rise", 256'(dfp_read), 256'(1'b1));
      check("write_low", 256'(dfp_write), 256'(1'b0));
      check("fill_addr", 256'(dfp_addr), 256'(v.exp_dfp));
      check("busy_high", 256'(busy), 256'(1'b1));
      repeat (v.delay) begin
         step();
         check("read_hold", 256'(dfp_read), 256'(1'b1));
      end
      dfp_resp  = 1'b1;
      dfp_rdata = rdata;
      step();
      dfp_resp  = 1'b0;
      dfp_rdata = ~rdata;
      check("read_drop", 256'(dfp_read), 256'(1'b0));
      check("fill_we", 256'(fill_we), 256'(1'b1));
      check("fill_way", 256'(fill_way), 256'(v.exp_way));
      check("fill_set", 256'(fill_set), 256'(v.exp_set));
      check("fill_tag", 256'(fill_tag), 256'(v.exp_tag));
      check("fill_data", fill_data, rdata);
      check("done_early", 256'(miss_done), 256'(1'b0));
      step();
      check("fill_we_pulse", 256'(fill_we), 256'(1'b0));
      check("miss_done", 256'(miss_done), 256'(1'b1));
      check("busy_replay", 256'(busy), 256'(1'b1));
      step();
      miss_req = 1'b0;
      check("done_pulse", 256'(miss_done), 256'(1'b0));
      check("busy_idle", 256'(busy), 256'(1'b0));
      exp_fills++;
   endtask

   initial begin
      vecs[0] = '{32'h0000_1234, 4'b1011, 4'h0, 3'b000, 3, 2'd2, 32'h0000_1220, 4'h1, 24'h000012};
      vecs[1] = '{32'hDEAD_BEEF, 4'hF,    4'h0, 3'b101, 0, 2'd3, 32'hDEAD_BEE0, 4'h7, 24'hDEADBE};
      vecs[2] = '{32'h1234_5678, 4'hF,    4'h0, 3'b010, 1, 2'd1, 32'h1234_5660, 4'h3, 24'h123456};
      vecs[3] = '{32'hFFFF_FFFF, 4'h0,    4'h0, 3'b111, 2, 2'd0, 32'hFFFF_FFE0, 4'hF, 24'hFFFFFF};
      vecs[4] = '{32'h0000_0100, 4'b0111, 4'h0, 3'b000, 0, 2'd3, 32'h0000_0100, 4'h8, 24'h000001};
      vecs[5] = '{32'h8000_0020, 4'hF,    4'h0, 3'b000, 4, 2'd0, 32'h8000_0020, 4'h1, 24'h800000};
      vecs[6] = '{32'h0000_03E0, 4'hF,    4'h0, 3'b110, 1, 2'd2, 32'h0000_03E0, 4'hF, 24'h000003};
      vecs[7] = '{32'h4000_0000, 4'b1101, 4'hF, 3'b000, 2, 2'd1, 32'h4000_0000, 4'h0, 24'h400000};

      rst       = 1'b1;
      miss_req  = 1'b0;
      miss_addr = '0;
      valid_vec = '0;
      dirty_vec = '0;
      lru_bits  = '0;
      tag_vec   = {24'h333333, 24'h222222, 24'h111111, 24'hABCDEF};
      data_vec  = {{8{32'h3333_3333}}, {8{32'h2222_2222}}, {8{32'h1111_1111}}, {8{32'hC0DE_F00D}}};
      dfp_rdata = '0;
      dfp_resp  = 1'b0;
      step();
      step();
      check("rst_read", 256'(dfp_read), 256'(1'b0));
      check("rst_write", 256'(dfp_write), 256'(1'b0));
      check("rst_addr", 256'(dfp_addr), 256'(32'h0));
      check("rst_fill_we", 256'(fill_we), 256'(1'b0));
      check("rst_done", 256'(miss_done), 256'(1'b0));
      check("rst_busy", 256'(busy), 256'(1'b0));
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         run_miss(vecs[i], {8{32'hA5A5_0000 | 32'(i)}});
         check("wdata_idle", dfp_wdata, 256'h0);
         step();
      end

      // Back-to-back: the second miss is sampled in the cycle right after miss_done.
      run_miss(vecs[0], {8{32'h0B2B_0001}});
      run_miss(vecs[1], {8{32'h0B2B_0002}});
      step();

      // Zero-wait memory: dfp_resp held high throughout.
      dfp_resp  = 1'b1;
      miss_req  = 1'b1;
      miss_addr = 32'h0000_2040;
      valid_vec = 4'b1110;
      dirty_vec = 4'h0;
      step();
      check("zw_read", 256'(dfp_read), 256'(1'b1));
      check("zw_addr", 256'(dfp_addr), 256'(32'h0000_2040));
      step();
      check("zw_read_drop", 256'(dfp_read), 256'(1'b0));
      check("zw_fill_we", 256'(fill_we), 256'(1'b1));
      check("zw_fill_set", 256'(fill_set), 256'(4'h2));
      check("zw_fill_tag", 256'(fill_tag), 256'(24'h000020));
      step();
      check("zw_fill_pulse", 256'(fill_we), 256'(1'b0));
      check("zw_done", 256'(miss_done), 256'(1'b1));
      step();
      miss_req = 1'b0;
      check("zw_done_pulse", 256'(miss_done), 256'(1'b0));
      check("zw_busy", 256'(busy), 256'(1'b0));
      exp_fills++;
      step();
      check("zw_idle_read", 256'(dfp_read), 256'(1'b0));
      check("zw_idle_busy", 256'(busy), 256'(1'b0));
      dfp_resp = 1'b0;

      // Reset in the middle of FILL abandons the read immediately.
      miss_req  = 1'b1;
      miss_addr = 32'h0000_5000;
      valid_vec = 4'h0;
      step();
      check("rf_read", 256'(dfp_read), 256'(1'b1));
      step();
      rst = 1'b1;
      #1;
      check("rf_read_zero", 256'(dfp_read), 256'(1'b0));
      check("rf_addr_zero", 256'(dfp_addr), 256'(32'h0));
      check("rf_busy_zero", 256'(busy), 256'(1'b0));
      miss_req = 1'b0;
      step();
      rst = 1'b0;
      step();
      run_miss(vecs[2], {8{32'h5EED_0003}});
      step();

      // Dirty victim in way 0 (tag 0xABCDEF), set 5.
      miss_req  = 1'b1;
      miss_addr = 32'h1111_10A0;
      valid_vec = 4'hF;
      dirty_vec = 4'b0001;
      lru_bits  = 3'b000;
      step();
`ifdef CACHE_WRITEBACK_EN
      check("wb_write", 256'(dfp_write), 256'(1'b1));
      check("wb_read_low", 256'(dfp_read), 256'(1'b0));
      check("wb_addr", 256'(dfp_addr), 256'(32'hABCD_EFA0));
      check("wb_wdata", dfp_wdata, {8{32'hC0DE_F00D}});
      step();
      check("wb_hold", 256'(dfp_write), 256'(1'b1));
      dfp_resp = 1'b1;
      step();
      dfp_resp = 1'b0;
      check("wb_write_drop", 256'(dfp_write), 256'(1'b0));
      check("wb_then_read", 256'(dfp_read), 256'(1'b1));
      check("wb_fill_addr", 256'(dfp_addr), 256'(32'h1111_10A0));
`else
      check("wt_write_low", 256'(dfp_write), 256'(1'b0));
      check("wt_wdata_zero", dfp_wdata, 256'h0);
      check("wt_read", 256'(dfp_read), 256'(1'b1));
      check("wt_addr", 256'(dfp_addr), 256'(32'h1111_10A0));
`endif
      dfp_resp  = 1'b1;
      dfp_rdata = {8{32'hF111_0005}};
      step();
      dfp_resp = 1'b0;
      check("dv_fill_we", 256'(fill_we), 256'(1'b1));
      check("dv_fill_way", 256'(fill_way), 256'(2'd0));
      check("dv_fill_set", 256'(fill_set), 256'(4'h5));
      check("dv_fill_tag", 256'(fill_tag), 256'(24'h111110));
      step();
      check("dv_done", 256'(miss_done), 256'(1'b1));
      step();
      miss_req = 1'b0;
      check("dv_busy", 256'(busy), 256'(1'b0));
      exp_fills++;
      step();

      check("fill_count", 256'(fill_cnt), 256'(exp_fills));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
